// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared widths and the buffered write-back entry type
package wb_arbiter_pkg;
    localparam int WORDSIZE  = 32;
    localparam int REG_NUM   = 32;
    localparam int REGADDR_W = 5;
    typedef logic [REGADDR_W-1:0] regaddr_t;
    typedef logic [WORDSIZE-1:0]  word_t;
    typedef struct packed {
        regaddr_t rd;
        word_t    data;
    } wb_entry_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: execute/memory-side result bus, decode scoreboard and register file write port
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;
    logic               alu_valid;
    regaddr_t           alu_rd;
    word_t              alu_data;
    logic               ll_valid;
    logic               ll_ready;
    regaddr_t           ll_rd;
    word_t              ll_data;
    logic               issue_valid;
    regaddr_t           issue_rd;
    logic [REG_NUM-1:0] busy;
    regaddr_t           write1;
    word_t              write_data;
    logic               regwrite;
    modport master (
        output alu_valid, alu_rd, alu_data, ll_valid, ll_rd, ll_data, issue_valid, issue_rd,
        input  ll_ready, busy, write1, write_data, regwrite
    );
    modport slave (
        input  alu_valid, alu_rd, alu_data, ll_valid, ll_rd, ll_data, issue_valid, issue_rd,
        output ll_ready, busy, write1, write_data, regwrite
    );
endinterface

// File: rtl/wb_arbiter_fifo.sv
// wb_fifo: synchronous FIFO with wrapping pointers and an explicit occupancy count
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;
    always_comb begin
        full    = count == (AW+1)'(DEPTH);
        empty   = count == '0;
        do_push = push && !full;
        do_pop  = pop && !empty;
        dout    = mem[rptr];
    end
    always_ff @(posedge CLK) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(do_push);
            rptr  <= rptr + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge CLK)
        if (do_push) mem[wptr] <= din;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and buffered long-latency results onto the single register file
// write port and tracks pending long-latency destinations for decode hazard stalls
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic          CLK,
    input  logic          reset,
    wb_arbiter_if.slave   wb
);
    wb_entry_t                   head;
    logic                        full, empty, push, pop;
    logic [$clog2(FIFO_DEPTH):0] count;
    logic [REG_NUM-1:0]          set_mask, clr_mask;
    always_comb begin
        push     = wb.ll_valid && wb.ll_ready;
        pop      = !wb.alu_valid && !empty;
        set_mask = (wb.issue_valid && wb.issue_rd != '0) ? REG_NUM'(1) << wb.issue_rd : '0;
        clr_mask = pop ? REG_NUM'(1) << head.rd : '0;
    end
    assign wb.ll_ready = reset && !full;
    wb_fifo #(.WIDTH($bits(wb_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK   (CLK),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({wb.ll_rd, wb.ll_data}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    // set is ORed in after the clear so a re-issue in the retiring cycle stays pending
    always_ff @(posedge CLK) begin
        if (!reset) begin
            wb.busy       <= '0;
            wb.regwrite   <= 1'b0;
            wb.write1     <= '0;
            wb.write_data <= '0;
        end else begin
            wb.busy <= (wb.busy & ~clr_mask) | set_mask;
            if (wb.alu_valid) begin
                wb.regwrite   <= wb.alu_rd != '0;
                wb.write1     <= wb.alu_rd;
                wb.write_data <= wb.alu_data;
            end else if (pop) begin
                wb.regwrite   <= head.rd != '0;
                wb.write1     <= head.rd;
                wb.write_data <= head.data;
            end else begin
                wb.regwrite   <= 1'b0;
            end
        end
    end
    a_issue_busy: assert property (@(posedge CLK) disable iff (!reset)
        wb.issue_valid && wb.issue_rd != '0 |-> !wb.busy[wb.issue_rd] || (pop && head.rd == wb.issue_rd));
    a_alu_busy: assert property (@(posedge CLK) disable iff (!reset)
        wb.alu_valid |-> !wb.busy[wb.alu_rd]);
    a_ll_unissued: assert property (@(posedge CLK) disable iff (!reset)
        push && wb.ll_rd != '0 |-> wb.busy[wb.ll_rd]);
    a_count_range: assert property (@(posedge CLK) disable iff (!reset)
        count <= ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH) && (empty == (count == '0)));
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vectors for ALU/LL arbitration, scoreboard and mid-operation reset
module tb_wb_arbiter;
    logic CLK = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;
    int   pushed;
    logic acc;
    wb_arbiter_if wb();
    wb_arbiter #(.FIFO_DEPTH(4)) dut (.CLK(CLK), .reset(reset), .wb(wb));
    always #5 CLK = ~CLK;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask
    task automatic idle();
        wb.alu_valid   = 1'b0;
        wb.alu_rd      = '0;
        wb.alu_data    = '0;
        wb.ll_valid    = 1'b0;
        wb.ll_rd       = '0;
        wb.ll_data     = '0;
        wb.issue_valid = 1'b0;
        wb.issue_rd    = '0;
    endtask
    task automatic issue(input int rd);
        wb.issue_valid = 1'b1;
        wb.issue_rd    = 5'(rd);
        tick();
        wb.issue_valid = 1'b0;
    endtask
    initial begin
        reset = 1'b0;
        idle();
        tick();
        tick();
        check("rst_regwrite", wb.regwrite, 0);
        check("rst_write1", wb.write1, 0);
        check("rst_wdata", wb.write_data, 0);
        check("rst_busy", wb.busy, 0);
        check("rst_ll_ready", wb.ll_ready, 0);
        reset = 1'b1;
        #1;
        check("ready_on_release", wb.ll_ready, 1);
        // ALU path: one cycle to the write port, rd 0 suppressed
        wb.alu_valid = 1'b1;
        wb.alu_rd    = 5'd3;
        wb.alu_data  = 32'h1111_1111;
        tick();
        check("alu_regwrite", wb.regwrite, 1);
        check("alu_write1", wb.write1, 3);
        check("alu_wdata", wb.write_data, 32'h1111_1111);
        wb.alu_rd   = 5'd0;
        wb.alu_data = 32'hDEAD_BEEF;
        tick();
        check("alu_rd0_regwrite", wb.regwrite, 0);
        wb.alu_valid = 1'b0;
        tick();
        check("alu_idle_regwrite", wb.regwrite, 0);
        // LL path with scoreboard
        issue(7);
        check("ll_busy_set", wb.busy[7], 1);
        wb.ll_valid = 1'b1;
        wb.ll_rd    = 5'd7;
        wb.ll_data  = 32'hCAFE_0007;
        check("ll_ready_empty", wb.ll_ready, 1);
        tick();
        wb.ll_valid = 1'b0;
        check("ll_push_regwrite", wb.regwrite, 0);
        check("ll_push_busy", wb.busy[7], 1);
        tick();
        check("ll_regwrite", wb.regwrite, 1);
        check("ll_write1", wb.write1, 7);
        check("ll_wdata", wb.write_data, 32'hCAFE_0007);
        check("ll_busy_clr", wb.busy[7], 0);
        // contention: ALU starves the FIFO until it fills
        for (int i = 0; i < 5; i++) issue(8 + i);
        check("cont_busy", wb.busy, 32'h0000_1F00);
        pushed = 0;
        for (int c = 0; c < 6; c++) begin
            wb.alu_valid = 1'b1;
            wb.alu_rd    = 5'd1;
            wb.alu_data  = 32'(c);
            wb.ll_valid  = 1'b1;
            wb.ll_rd     = 5'(8 + pushed);
            wb.ll_data   = 32'hA000_0000 + 32'(8 + pushed);
            check("cont_ready", wb.ll_ready, pushed < 4);
            acc = wb.ll_ready;
            tick();
            if (acc) pushed++;
            check("cont_alu_write1", wb.write1, 1);
            check("cont_alu_wdata", wb.write_data, c);
        end
        wb.alu_valid = 1'b0;
        check("drain_ready_full", wb.ll_ready, 0);
        for (int k = 0; k < 5; k++) begin
            wb.ll_valid = pushed < 5;
            wb.ll_rd    = 5'(8 + pushed);
            wb.ll_data  = 32'hA000_0000 + 32'(8 + pushed);
            acc = wb.ll_ready && wb.ll_valid;
            tick();
            if (acc) pushed++;
            check("drain_regwrite", wb.regwrite, 1);
            check("drain_write1", wb.write1, 8 + k);
            check("drain_wdata", wb.write_data, 32'hA000_0000 + 32'(8 + k));
        end
        wb.ll_valid = 1'b0;
        check("drain_busy", wb.busy, 0);
        // wrap-around: ten entries through the depth-4 FIFO
        for (int i = 0; i < 10; i++) issue(16 + i);
        for (int i = 0; i <= 10; i++) begin
            wb.ll_valid = i < 10;
            wb.ll_rd    = 5'(16 + i);
            wb.ll_data  = 32'hB000_0000 + 32'(i);
            tick();
            if (i > 0) begin
                check("wrap_write1", wb.write1, 16 + i - 1);
                check("wrap_wdata", wb.write_data, 32'hB000_0000 + 32'(i - 1));
            end
        end
        wb.ll_valid = 1'b0;
        check("wrap_count", dut.u_fifo.count, 0);
        check("wrap_busy", wb.busy, 0);
        // LL entry to r0 is popped and dropped
        wb.ll_valid = 1'b1;
        wb.ll_rd    = 5'd0;
        wb.ll_data  = 32'h0000_0BAD;
        tick();
        wb.ll_valid = 1'b0;
        tick();
        check("r0_regwrite", wb.regwrite, 0);
        check("r0_write1", wb.write1, 0);
        check("r0_count", dut.u_fifo.count, 0);
        // same-cycle clear and re-issue of r5
        issue(5);
        wb.ll_valid = 1'b1;
        wb.ll_rd    = 5'd5;
        wb.ll_data  = 32'h0000_00C5;
        tick();
        wb.ll_valid = 1'b0;
        issue(5);
        check("setclr_busy", wb.busy[5], 1);
        check("setclr_regwrite", wb.regwrite, 1);
        check("setclr_write1", wb.write1, 5);
        // reset with three queued entries
        for (int i = 0; i < 3; i++) issue(26 + i);
        for (int j = 0; j < 3; j++) begin
            wb.alu_valid = 1'b1;
            wb.alu_rd    = 5'd2;
            wb.alu_data  = 32'h2222_0000 + 32'(j);
            wb.ll_valid  = 1'b1;
            wb.ll_rd     = 5'(26 + j);
            wb.ll_data   = 32'hD000_0000 + 32'(j);
            tick();
        end
        idle();
        check("pre_rst_count", dut.u_fifo.count, 3);
        check("pre_rst_busy", wb.busy, 32'h1C00_0020);
        reset = 1'b0;
        tick();
        check("mid_rst_regwrite", wb.regwrite, 0);
        check("mid_rst_write1", wb.write1, 0);
        check("mid_rst_busy", wb.busy, 0);
        check("mid_rst_ready", wb.ll_ready, 0);
        check("mid_rst_count", dut.u_fifo.count, 0);
        reset = 1'b1;
        tick();
        check("post_rst_regwrite0", wb.regwrite, 0);
        tick();
        check("post_rst_regwrite1", wb.regwrite, 0);
        check("post_rst_ready", wb.ll_ready, 1);
        check("post_rst_busy", wb.busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
